// File: rtl/booth_pkg.sv
// Shared types and constants for the radix-4 Booth sequential multiplier.
package booth_pkg;

  localparam int unsigned OP_W    = 8;
  localparam int unsigned PROD_W  = 16;
  localparam int unsigned NDIGITS = 4;
  localparam int unsigned IDX_W   = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Booth triplet {x[2i+1], x[2i], x[2i-1]} with x[-1] = 0.
  function automatic logic [2:0] booth_triplet(input logic [OP_W-1:0] x,
                                               input logic [IDX_W-1:0] idx);
    logic [OP_W:0] ext;
    logic [OP_W:0] sh;
    ext = {x, 1'b0};
    sh  = ext >> {idx, 1'b0};
    return sh[2:0];
  endfunction

endpackage

// File: rtl/booth_pp_sel.sv
// Radix-4 Booth partial-product selector: decodes one triplet into a
// sign-extended, already-negated partial product of the multiplicand.
module booth_pp_sel
  import booth_pkg::*;
(
  input  logic [2:0]        triplet,
  input  logic [OP_W-1:0]   y,
  output logic [PROD_W-1:0] pp
);

  logic              w_single;
  logic              w_double;
  logic              w_neg;
  logic [PROD_W-1:0] w_y_ext;
  logic [PROD_W-1:0] w_mag;

  assign w_single = triplet[1] ^ triplet[0];
  assign w_double = (triplet == 3'b100) || (triplet == 3'b011);
  assign w_neg    = triplet[2];
  assign w_y_ext  = {{(PROD_W-OP_W){y[OP_W-1]}}, y};

  always_comb begin
    w_mag = '0;
    if (w_single)      w_mag = w_y_ext;
    else if (w_double) w_mag = w_y_ext << 1;
  end

  // A zero-magnitude digit with neg set (triplet 111) contributes exactly 0.
  assign pp = (w_neg && (w_mag != '0)) ? (~w_mag + PROD_W'(1)) : w_mag;

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential 8x8 signed radix-4 Booth multiplier: one digit per cycle,
// valid/ready handshakes on both operand and product sides.
module booth_mul_seq
  import booth_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   x,
  input  logic [OP_W-1:0]   y,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [OP_W-1:0]   r_x;
  logic [OP_W-1:0]   r_y;
  logic [PROD_W-1:0] r_acc;
  logic [IDX_W-1:0]  r_idx;
  logic              r_in_ready;
  logic              r_out_valid;
  logic [PROD_W-1:0] r_product;

  logic [2:0]        w_triplet;
  logic [PROD_W-1:0] w_pp;
  logic [PROD_W-1:0] w_pp_shift;
  logic [PROD_W-1:0] w_acc_sum;
  logic              w_last_digit;

  assign w_triplet    = booth_triplet(r_x, r_idx);
  assign w_pp_shift   = w_pp << {r_idx, 1'b0};
  assign w_acc_sum    = r_acc + w_pp_shift;
  assign w_last_digit = (r_idx == IDX_W'(NDIGITS - 1));

  booth_pp_sel u_pp_sel (
    .triplet (w_triplet),
    .y       (r_y),
    .pp      (w_pp)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid)     w_state_nxt = RUN;
      RUN:     if (w_last_digit) w_state_nxt = DONE;
      DONE:    if (out_ready)    w_state_nxt = IDLE;
      default:                   w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Operand latch, accumulator and digit index.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_x   <= '0;
      r_y   <= '0;
      r_acc <= '0;
      r_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_x   <= x;
            r_y   <= y;
            r_acc <= '0;
            r_idx <= '0;
          end
        end
        RUN: begin
          r_acc <= w_acc_sum;
          r_idx <= r_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs are registered off the next state so they track the state decode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_product   <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      if (w_state_nxt != DONE)  r_product <= '0;
      else if (r_state == RUN)  r_product <= w_acc_sum;
      else                      r_product <= r_acc;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign product   = r_product;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed cases plus a wide sweep
// against a plain signed-multiply reference.
module tb_booth_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  x;
  logic [7:0]  y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;

  int n_checks;
  int n_errors;

  booth_mul_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  // One full transaction: accept, compute, optional DONE stall, handshake.
  task automatic run_op(input logic [7:0] xv, input logic [7:0] yv,
                        input int stall, input bit chk_lat);
    logic [15:0] exp;
    int          cnt;
    exp = ref_mul(xv, yv);

    cnt = 0;
    while (!in_ready && cnt < 10) begin
      tick();
      cnt++;
    end
    if (!in_ready) check_eq("accept_timeout", 32'(in_ready), 32'd1);

    in_valid  = 1'b1;
    x         = xv;
    y         = yv;
    out_ready = 1'($urandom_range(0, 1));
    tick();
    check_eq("in_ready_low_after_accept", 32'(in_ready), 32'd0);

    // in_valid/out_ready noise while running must be ignored.
    cnt = 0;
    do begin
      in_valid  = 1'($urandom_range(0, 1));
      x         = 8'($urandom);
      y         = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick();
      cnt++;
      if (!out_valid) check_eq("product_zero_run", 32'(product), 32'd0);
    end while (!out_valid && cnt < 20);
    if (!out_valid) check_eq("done_timeout", 32'(out_valid), 32'd1);
    if (chk_lat) check_eq("latency", 32'(cnt), 32'd4);
    check_eq("product", 32'(product), 32'(exp));

    out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'($urandom_range(0, 1));
      x        = 8'($urandom);
      y        = 8'($urandom);
      tick();
      check_eq("stall_product", 32'(product), 32'(exp));
      check_eq("stall_out_valid", 32'(out_valid), 32'd1);
      check_eq("stall_in_ready", 32'(in_ready), 32'd0);
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("post_hs_in_ready", 32'(in_ready), 32'd1);
    check_eq("post_hs_out_valid", 32'(out_valid), 32'd0);
    check_eq("post_hs_product", 32'(product), 32'd0);
  endtask

  logic [7:0] y_corner [16];

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    x         = '0;
    y         = '0;

    tick();
    tick();
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed cases with exact expected products.
    run_op(8'd3, 8'd5, 0, 1'b1);
    check_eq("ref_3x5", 32'(ref_mul(8'd3, 8'd5)), 32'h000F);
    run_op(8'h80, 8'h80, 0, 1'b1);
    run_op(8'h7F, 8'h80, 1, 1'b1);
    run_op(8'hFF, 8'h7F, 0, 1'b1);
    run_op(8'hFE, 8'd9, 3, 1'b1);

    // Reset on the second RUN edge aborts the operation.
    in_valid = 1'b1;
    x        = 8'h55;
    y        = 8'h33;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrun_rst_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    run_op(8'd4, 8'hFD, 0, 1'b1);

    // Reset during DONE with out_ready high: reset wins, no product.
    in_valid = 1'b1;
    x        = 8'd7;
    y        = 8'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check_eq("pre_rst_done_out_valid", 32'(out_valid), 32'd1);
    rst_n     = 1'b0;
    out_ready = 1'b1;
    tick();
    check_eq("done_rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("done_rst_product", 32'(product), 32'd0);
    rst_n     = 1'b1;
    out_ready = 1'b0;

    // Every multiplier value against corner and random multiplicands.
    y_corner = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h7F, 8'h80, 8'h81, 8'hFF,
                 8'hFE, 8'h40, 8'hC0, 8'h55, 8'hAA, 8'h3F, 8'h00, 8'h00};
    for (int xi = 0; xi < 256; xi++) begin
      y_corner[14] = 8'($urandom);
      y_corner[15] = 8'($urandom);
      for (int yi = 0; yi < 16; yi++)
        run_op(8'(xi), y_corner[yi], ($urandom_range(0, 7) == 0) ? 1 : 0, 1'b0);
    end

    for (int k = 0; k < 1500; k++)
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
